// File: rtl/strob_seq.sv
// -----------------------------------------------------------------------------
// strob_seq -- microcycle strobe sequencer
//
// Runs one microcycle as IDLE -> S1 -> [WAIT] -> [S2] -> GOT. S1 drives
// strob1 for S1_TICKS clocks. WAIT holds until memory acknowledges. S2
// drives strob2 for S2_TICKS clocks. GOT pulses got for one clock, which
// advances the microprogram. All outputs are registered.
//
// Parameters
//   S1_TICKS  clocks strob1 is high per microcycle (1..15)
//   S2_TICKS  clocks strob2 is high per microcycle (1..15)
//   TIMEOUT   maximum clocks spent in WAIT when the timeout is built (1..255)
//
// Ports
//   clk_sys           system clock, rising edge
//   clr_              asynchronous active-low reset
//   run               continuous microcycle execution enable
//   step              single-microcycle request, honoured only in IDLE
//   as2               microcycle is two-phase (needs strob2)
//   wm                microcycle waits for a memory acknowledge
//   ok$               memory acknowledge, active high
//   strob1 / strob1_  first-phase strobe and its complement
//   strob2 / strob2_  second-phase strobe and its complement
//   got               one-clock end-of-microcycle pulse
//   busy              high in every state except IDLE
//   alarm             sticky memory-timeout flag
//
// Build option
//   STROB_SEQ_TIMEOUT_EN  when defined, WAIT is bounded by TIMEOUT clocks.
//                         When it times out, alarm is set and the cycle
//                         continues as if acknowledged. When undefined,
//                         WAIT is unbounded and alarm is tied to 0.
// -----------------------------------------------------------------------------
module strob_seq #(
  parameter int unsigned S1_TICKS = 2,
  parameter int unsigned S2_TICKS = 2,
  parameter int unsigned TIMEOUT  = 200
) (
  input  logic clk_sys,
  input  logic clr_,
  input  logic run,
  input  logic step,
  input  logic as2,
  input  logic wm,
  input  logic ok$,
  output logic strob1,
  output logic strob1_,
  output logic strob2,
  output logic strob2_,
  output logic got,
  output logic busy,
  output logic alarm
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_S1   = 3'd1,
    ST_WAIT = 3'd2,
    ST_S2   = 3'd3,
    ST_GOT  = 3'd4
  } state_t;

  localparam logic [3:0] S1_LAST = 4'(S1_TICKS - 1);
  localparam logic [3:0] S2_LAST = 4'(S2_TICKS - 1);

  state_t     state_r;
  state_t     state_s;
  logic [3:0] tick_r;
  logic [3:0] tick_s;
  logic       ok_lat_r;
  logic       ok_lat_s;
  logic       as2_hold_r;
  logic       as2_hold_s;
  logic       guard_r;
  logic       guard_s;
  logic       armed_r;
  logic       ok_seen_s;
  logic       timeout_hit_s;

  // An acknowledge counts whether it arrived earlier (latched) or right now.
  assign ok_seen_s = ok_lat_r | ok$;

`ifdef STROB_SEQ_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [7:0] wait_cnt_r;
  logic [7:0] wait_cnt_s;
  logic       alarm_r;
  logic       alarm_s;

  // WAIT watchdog: counts unacknowledged WAIT clocks and raises the sticky alarm.
  always_comb begin
    timeout_hit_s = 1'b0;
    wait_cnt_s    = 8'd0;
    alarm_s       = alarm_r;
    if ((state_r == ST_WAIT) && !ok_seen_s) begin
      if (wait_cnt_r == TO_LAST) begin
        timeout_hit_s = 1'b1;
        alarm_s       = 1'b1;
      end else begin
        wait_cnt_s = wait_cnt_r + 8'd1;
      end
    end else begin
      wait_cnt_s = 8'd0;
    end
  end

  // Watchdog counter and alarm registers.
  always_ff @(posedge clk_sys or negedge clr_) begin
    if (!clr_) begin
      wait_cnt_r <= 8'd0;
      alarm_r    <= 1'b0;
    end else begin
      wait_cnt_r <= wait_cnt_s;
      alarm_r    <= alarm_s;
    end
  end

  assign alarm = alarm_r;
`else
  assign timeout_hit_s = 1'b0;
  assign alarm         = 1'b0;
`endif

  // Next-state logic for the microcycle sequencer.
  always_comb begin
    state_s    = state_r;
    tick_s     = tick_r;
    ok_lat_s   = ok_lat_r | ok$;
    as2_hold_s = as2_hold_r;
    guard_s    = guard_r;
    case (state_r)
      ST_IDLE: begin
        ok_lat_s = 1'b0;
        tick_s   = 4'd0;
        guard_s  = 1'b0;
        // armed_r keeps the first edge after reset release in IDLE.
        if (armed_r && (run || step)) begin
          state_s = ST_S1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_S1: begin
        if (tick_r == S1_LAST) begin
          tick_s     = 4'd0;
          as2_hold_s = as2;
          // wm only steers this one transition, so it needs no holding register.
          if (wm) begin
            state_s = ST_WAIT;
          end else if (as2) begin
            // Direct S1->S2: insert one dead clock so the strobes never touch.
            state_s = ST_S2;
            guard_s = 1'b1;
          end else begin
            state_s = ST_GOT;
          end
        end else begin
          tick_s = tick_r + 4'd1;
        end
      end
      ST_WAIT: begin
        if (ok_seen_s || timeout_hit_s) begin
          tick_s  = 4'd0;
          guard_s = 1'b0;
          if (as2_hold_r) begin
            state_s = ST_S2;
          end else begin
            state_s = ST_GOT;
          end
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_S2: begin
        if (guard_r) begin
          guard_s = 1'b0;
        end else if (tick_r == S2_LAST) begin
          tick_s  = 4'd0;
          state_s = ST_GOT;
        end else begin
          tick_s = tick_r + 4'd1;
        end
      end
      ST_GOT: begin
        ok_lat_s = 1'b0;
        tick_s   = 4'd0;
        guard_s  = 1'b0;
        if (run) begin
          state_s = ST_S1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: begin
        state_s  = ST_IDLE;
        tick_s   = 4'd0;
        ok_lat_s = 1'b0;
        guard_s  = 1'b0;
      end
    endcase
  end

  // Sequencer state and per-cycle bookkeeping registers.
  always_ff @(posedge clk_sys or negedge clr_) begin
    if (!clr_) begin
      state_r    <= ST_IDLE;
      tick_r     <= 4'd0;
      ok_lat_r   <= 1'b0;
      as2_hold_r <= 1'b0;
      guard_r    <= 1'b0;
      armed_r    <= 1'b0;
    end else begin
      state_r    <= state_s;
      tick_r     <= tick_s;
      ok_lat_r   <= ok_lat_s;
      as2_hold_r <= as2_hold_s;
      guard_r    <= guard_s;
      armed_r    <= 1'b1;
    end
  end

  // Registered outputs, decoded from the next state so they align with it.
  always_ff @(posedge clk_sys or negedge clr_) begin
    if (!clr_) begin
      strob1  <= 1'b0;
      strob1_ <= 1'b1;
      strob2  <= 1'b0;
      strob2_ <= 1'b1;
      got     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      strob1  <= (state_s == ST_S1);
      strob1_ <= (state_s != ST_S1);
      strob2  <= (state_s == ST_S2) && !guard_s;
      strob2_ <= !((state_s == ST_S2) && !guard_s);
      got     <= (state_s == ST_GOT);
      busy    <= (state_s != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_strob_seq.sv
// -----------------------------------------------------------------------------
// tb_strob_seq -- self-checking bench for strob_seq.
// Each microcycle is expanded into a per-clock table of expected outputs,
// built from its phases: S1 clocks, wait clocks, a dead clock, S2 clocks, and
// the got clock. The same table row also carries the inputs for that clock.
// -----------------------------------------------------------------------------
module tb_strob_seq;
  localparam int S1T = 2;
  localparam int S2T = 2;
  localparam int TO  = 10;

  logic clk_sys = 1'b0;
  logic clr_    = 1'b0;
  logic run     = 1'b0;
  logic step    = 1'b0;
  logic as2     = 1'b0;
  logic wm      = 1'b0;
  logic ok      = 1'b0;
  logic strob1, strob1_, strob2, strob2_, got, busy, alarm;

  int checks   = 0;
  int failures = 0;
  bit alarm_m  = 1'b0;

  typedef struct {
    bit s1, s2, g, b, al;
    bit run_i, step_i, as2_i, wm_i, ok_i;
  } row_t;
  row_t q[$];

  strob_seq #(.S1_TICKS(S1T), .S2_TICKS(S2T), .TIMEOUT(TO)) dut (
    .clk_sys(clk_sys), .clr_(clr_), .run(run), .step(step), .as2(as2),
    .wm(wm), .ok$(ok), .strob1(strob1), .strob1_(strob1_), .strob2(strob2),
    .strob2_(strob2_), .got(got), .busy(busy), .alarm(alarm)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit rb();
    return bit'($urandom_range(0, 1));
  endfunction

  task automatic add_row(input bit s1, input bit s2, input bit g, input bit b,
                         input bit r_i, input bit st_i, input bit a_i,
                         input bit w_i, input bit o_i);
    row_t r;
    r.s1 = s1; r.s2 = s2; r.g = g; r.b = b; r.al = alarm_m;
    r.run_i = r_i; r.step_i = st_i; r.as2_i = a_i; r.wm_i = w_i; r.ok_i = o_i;
    q.push_back(r);
  endtask

  task automatic add_idle(input bit r_i, input bit st_i);
    add_row(1'b0, 1'b0, 1'b0, 1'b0, r_i, st_i, 1'b0, 1'b0, 1'b0);
  endtask

  // mode 0: ack on the d-th wait clock; 1: ack pulse in S1; 2: never ack.
  task automatic plan_cycle(input bit a2, input bit w, input int mode,
                            input int d, input bit r);
    int wl;
`ifndef STROB_SEQ_TIMEOUT_EN
    if (mode == 2) begin
      mode = 0;
      d    = TO + 20;
    end
`endif
    for (int i = 0; i < S1T; i++)
      add_row(1'b1, 1'b0, 1'b0, 1'b1, r, rb(), a2, w, (mode == 1) && (i == 0));
    if (w) begin
      wl = (mode == 1) ? 1 : ((mode == 2) ? TO : d);
      for (int j = 0; j < wl; j++)
        add_row(1'b0, 1'b0, 1'b0, 1'b1, r, rb(), rb(), rb(),
                (mode == 0) && (j == wl - 1));
      if (mode == 2) alarm_m = 1'b1;
    end
    if (a2 && !w) add_row(1'b0, 1'b0, 1'b0, 1'b1, r, rb(), rb(), rb(), 1'b0);
    if (a2)
      for (int k = 0; k < S2T; k++)
        add_row(1'b0, 1'b1, 1'b0, 1'b1, r, rb(), rb(), rb(), 1'b0);
    add_row(1'b0, 1'b0, 1'b1, 1'b1, r, rb(), rb(), rb(), 1'b0);
  endtask

  task automatic check_row(input row_t r);
    check1("strob1", strob1, r.s1);
    check1("strob1_", strob1_, !r.s1);
    check1("strob2", strob2, r.s2);
    check1("strob2_", strob2_, !r.s2);
    check1("got", got, r.g);
    check1("busy", busy, r.b);
    check1("alarm", alarm, r.al);
    check1("strobe_overlap", strob1 & strob2, 1'b0);
  endtask

  task automatic exec_row(output row_t r);
    r = q.pop_front();
    @(negedge clk_sys);
    check_row(r);
    run = r.run_i; step = r.step_i; as2 = r.as2_i; wm = r.wm_i; ok = r.ok_i;
  endtask

  task automatic exec_all();
    row_t r;
    while (q.size() > 0) exec_row(r);
  endtask

  task automatic rand_burst();
    bit use_step;
    int n, mode;
    use_step = rb();
    n = use_step ? 1 : $urandom_range(1, 4);
    add_idle(!use_step, use_step);
    for (int c = 0; c < n; c++) begin
      mode = ($urandom_range(0, 5) == 0) ? 2 : $urandom_range(0, 1);
      plan_cycle(rb(), rb(), mode, $urandom_range(1, 6), use_step ? 1'b0 : (c < n - 1));
    end
    add_idle(1'b0, 1'b0);
    add_idle(1'b0, 1'b0);
    exec_all();
  endtask

  task automatic release_reset();
    @(negedge clk_sys);
    clr_ = 1'b1;
    run  = 1'b1;
  endtask

  initial begin
    row_t r;
    // Reset state, with run held high throughout reset.
    run = 1'b1;
    repeat (3) @(negedge clk_sys);
    check1("rst_strob1", strob1, 1'b0);
    check1("rst_strob1_", strob1_, 1'b1);
    check1("rst_strob2", strob2, 1'b0);
    check1("rst_strob2_", strob2_, 1'b1);
    check1("rst_got", got, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check1("rst_alarm", alarm, 1'b0);

    // Release with run=1: first edge stays IDLE, S1 begins on the second.
    // Two-phase waiting cycle (ack on 5th wait clock), then a one-phase cycle.
    release_reset();
    add_idle(1'b1, 1'b0);
    plan_cycle(1'b1, 1'b1, 0, 5, 1'b1);
    plan_cycle(1'b0, 1'b0, 0, 1, 1'b0);
    add_idle(1'b0, 1'b0); add_idle(1'b0, 1'b0);
    exec_all();

    // Single step.
    add_idle(1'b0, 1'b1);
    plan_cycle(1'b0, 1'b0, 0, 1, 1'b0);
    add_idle(1'b0, 1'b0); add_idle(1'b0, 1'b0);
    exec_all();

    // Early acknowledge during S1.
    add_idle(1'b1, 1'b0);
    plan_cycle(1'b0, 1'b1, 1, 1, 1'b0);
    add_idle(1'b0, 1'b0); add_idle(1'b0, 1'b0);
    exec_all();

    // Guarded S1->S2 with no wait.
    add_idle(1'b0, 1'b1);
    plan_cycle(1'b1, 1'b0, 0, 1, 1'b0);
    add_idle(1'b0, 1'b0);
    exec_all();

    // No acknowledge: timeout (or a long wait when the timeout is not built).
    add_idle(1'b0, 1'b1);
    plan_cycle(1'b1, 1'b1, 2, 1, 1'b0);
    add_idle(1'b0, 1'b0); add_idle(1'b0, 1'b0); add_idle(1'b0, 1'b0);
    exec_all();

    // Back-to-back: three one-phase cycles, then run drops.
    add_idle(1'b1, 1'b0);
    plan_cycle(1'b0, 1'b0, 0, 1, 1'b1);
    plan_cycle(1'b0, 1'b0, 0, 1, 1'b1);
    plan_cycle(1'b0, 1'b0, 0, 1, 1'b0);
    add_idle(1'b0, 1'b0); add_idle(1'b0, 1'b0);
    exec_all();

    repeat (25) rand_burst();

    // Reset in the middle of S2.
    add_idle(1'b0, 1'b1);
    plan_cycle(1'b1, 1'b1, 0, 2, 1'b0);
    r.s2 = 1'b0;
    while (!r.s2 && q.size() > 0) exec_row(r);
    check1("reached_s2", r.s2, 1'b1);
    #2;
    clr_ = 1'b0;
    #1;
    check1("midrst_strob2", strob2, 1'b0);
    check1("midrst_strob2_", strob2_, 1'b1);
    check1("midrst_strob1", strob1, 1'b0);
    check1("midrst_got", got, 1'b0);
    check1("midrst_busy", busy, 1'b0);
    check1("midrst_alarm", alarm, 1'b0);
    q.delete();
    alarm_m = 1'b0;
    run = 1'b0; step = 1'b0; as2 = 1'b0; wm = 1'b0; ok = 1'b0;
    repeat (2) begin
      @(negedge clk_sys);
      check1("inrst_got", got, 1'b0);
      check1("inrst_busy", busy, 1'b0);
    end

    // Restart after reset.
    release_reset();
    add_idle(1'b1, 1'b0);
    plan_cycle(1'b1, 1'b0, 0, 1, 1'b0);
    add_idle(1'b0, 1'b0); add_idle(1'b0, 1'b0);
    exec_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/strob_seq.md
STROB_SEQ -- requirements
Module: strob_seq

Interface
REQ-001 Parameter S1_TICKS, default 2: clocks strob1 is held high per microcycle, legal 1..15.
REQ-002 Parameter S2_TICKS, default 2: clocks strob2 is held high per microcycle, legal 1..15.
REQ-003 Parameter TIMEOUT, default 200: maximum clocks spent waiting for memory, legal 1..255.
REQ-004 clk_sys  in  1  system clock; all state changes on its rising edge.
REQ-005 clr_  in  1  reset, asynchronous, active-low.
REQ-006 run  in  1  continuous microcycle execution enable.
REQ-007 step  in  1  single-microcycle request, sampled only in IDLE.
REQ-008 as2  in  1  current microcycle is two-phase and needs strob2.
REQ-009 wm  in  1  current microcycle waits for a memory acknowledge.
REQ-010 ok$  in  1  memory acknowledge, active-high.
REQ-011 strob1, strob1_  out  1  first-phase strobe and its exact complement.
REQ-012 strob2, strob2_  out  1  second-phase strobe and its exact complement.
REQ-013 got  out  1  one-clock end-of-microcycle pulse that advances the microprogram.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 alarm  out  1  sticky memory-timeout flag.

Function
REQ-016 States SHALL be IDLE, S1, WAIT, S2 and GOT; all outputs SHALL be registered, with strobX_ always equal to ~strobX.
REQ-017 IDLE SHALL go to S1 when run=1 or step=1; run has priority, and both together start one cycle.
REQ-018 S1 SHALL hold strob1=1 for exactly S1_TICKS clocks, then go to WAIT if wm=1, else to S2 if as2=1, else to GOT.
REQ-019 as2 and wm SHALL be sampled on the last S1 clock and held for the rest of the microcycle.
REQ-020 An ok$=1 seen on any clock from S1 entry SHALL be latched; WAIT SHALL exit on the first clock where the latch or ok$ is 1.
REQ-021 WAIT exit SHALL go to S2 if the held as2=1, else to GOT.
REQ-022 S2 SHALL hold strob2=1 for exactly S2_TICKS clocks, then go to GOT.
REQ-023 GOT SHALL last one clock with got=1, clear the ok latch and tick counter, then go to S1 if run=1, else to IDLE.
REQ-024 strob1 and strob2 SHALL never be high on the same clock, and at least one clock SHALL separate them.
REQ-025 Deasserting run mid-cycle SHALL let the current microcycle complete through GOT, then enter IDLE.
REQ-026 step outside IDLE SHALL be ignored and not queued.
REQ-027 With run=1 continuously, got SHALL pulse every S1_TICKS+1 clocks for one-phase no-wait cycles (S1 and GOT).

Reset
REQ-028 While clr_=0, the state SHALL be IDLE and strob1=strob2=0, strob1_=strob2_=1, got=0, busy=0, alarm=0, with the ok latch and all counters cleared.
REQ-029 Reset asserted mid-cycle SHALL abort the cycle immediately, with no got pulse.
REQ-030 After clr_ deasserts, the first S1 SHALL occur no earlier than the second rising edge.

Configuration
REQ-031 Macro STROB_SEQ_TIMEOUT_EN: when defined, an 8-bit counter SHALL run in WAIT.
REQ-032 With the macro defined, reaching TIMEOUT clocks without an acknowledge SHALL set alarm, which stays set until reset, and the sequencer SHALL proceed as if ok$ had arrived.
REQ-033 Without the macro, WAIT SHALL have no time limit, and alarm SHALL be constant 0 with the port still present.

Verification
REQ-034 Single step: defaults, run=0, as2=0, wm=0, step pulsed one clock -> strob1 high 2 clocks, got high 1 clock, then IDLE with busy=0.
REQ-035 Two-phase with memory: run=1, as2=1, wm=1, ok$ raised 5 clocks after WAIT entry -> strob1 2 clocks, WAIT 5 clocks, strob2 2 clocks, got 1 clock, then S1 again.
REQ-036 Early acknowledge: ok$ pulsed one clock during S1 with wm=1 -> WAIT lasts 1 clock and the cycle completes normally.
REQ-037 Timeout, macro defined, TIMEOUT=10, ok$ never asserted -> alarm rises after 10 WAIT clocks, the cycle completes with got, and alarm stays 1 until clr_=0.
REQ-038 Reset mid-S2: clr_ pulsed low -> strob2=0 and strob2_=1 immediately, no got, state IDLE.
REQ-039 Back-to-back: run=1 for 3 one-phase cycles, then run=0 -> exactly 3 got pulses spaced 3 clocks apart, never overlapping strob1, and busy ends low.
